// File: rtl/ah_snoop_dedup_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ah_snoop_pkg
// Brief   : Shared types and constants for the snoop/dedup write stage.
// Revision: 1.0  initial release
// ============================================================================
package ah_snoop_pkg;

    localparam int DW_DEFAULT = 10;
    localparam int FIFO_DEPTH = 86;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        PUSH  = 2'd2
    } state_t;

endpackage : ah_snoop_pkg
`default_nettype wire

// File: rtl/ah_snoop_dedup_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : ah_snoop_dedup_writer_if
// Brief   : Upstream handshake plus FIFO write and snoop ports.
// Revision: 1.0  initial release
// ============================================================================
interface ah_snoop_dedup_writer_if #(
    parameter int DW = 10
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_wvalid;
    logic          fifo_wready;
    logic [DW-1:0] fifo_sdata;
    logic          fifo_svalid;
    logic          fifo_smatch;

    // master: the writer stage; slave: upstream source together with the FIFO
    modport master (
        input  in_data, in_valid, fifo_wready, fifo_smatch,
        output in_ready, fifo_wdata, fifo_wvalid, fifo_sdata, fifo_svalid
    );

    modport slave (
        output in_data, in_valid, fifo_wready, fifo_smatch,
        input  in_ready, fifo_wdata, fifo_wvalid, fifo_sdata, fifo_svalid
    );
endinterface : ah_snoop_dedup_writer_if
`default_nettype wire

// File: rtl/ah_snoop_dedup_writer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : ah_sat_counter
// Brief   : Event counter that holds at all-ones instead of wrapping.
// Revision: 1.0  initial release
// ============================================================================
module ah_sat_counter #(
    parameter int CNTW = 16
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    input  wire logic            inc,
    output logic [CNTW-1:0]      cnt
);
    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign cnt = r_cnt;
endmodule : ah_sat_counter
`default_nettype wire

// File: rtl/ah_snoop_dedup_writer.sv
`default_nettype none
// ============================================================================
// Module  : ah_snoop_dedup_writer
// Brief   : Holds each word for one snoop cycle, drops duplicates already
//           queued in the FIFO, otherwise pushes it; counts pushes/drops.
// Revision: 1.0  initial release
// ============================================================================
module ah_snoop_dedup_writer
    import ah_snoop_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int CNTW = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rstn,
    ah_snoop_dedup_writer_if.master   bus,
    input  wire logic                 dedup_en,
    output logic [CNTW-1:0]           push_cnt,
    output logic [CNTW-1:0]           drop_cnt
);
    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_hold;

    logic w_in_ready;
    logic w_wvalid;
    logic w_svalid;
    logic w_push_inc;
    logic w_drop_inc;
    logic w_capture;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = dedup_en ? SNOOP : PUSH;
                end
            end
            SNOOP: begin
                w_next_state = bus.fifo_smatch ? IDLE : PUSH;
            end
            PUSH: begin
                // A capture in the push cycle chains straight into the next word
                if (bus.fifo_wready) begin
                    if (bus.in_valid) begin
                        w_next_state = dedup_en ? SNOOP : PUSH;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_wvalid   = 1'b0;
        w_svalid   = 1'b0;
        w_push_inc = 1'b0;
        w_drop_inc = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
            end
            SNOOP: begin
                w_svalid   = 1'b1;
                w_drop_inc = bus.fifo_smatch;
            end
            PUSH: begin
                w_wvalid   = 1'b1;
                w_in_ready = bus.fifo_wready;
                w_push_inc = bus.fifo_wready;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    assign w_capture = w_in_ready & bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= bus.in_data;
        end
    end

    // Outputs are forced low while rstn is held, even before the reset edge
    assign bus.in_ready    = rstn & w_in_ready;
    assign bus.fifo_wvalid = rstn & w_wvalid;
    assign bus.fifo_svalid = rstn & w_svalid;
    assign bus.fifo_wdata  = rstn ? r_hold : '0;
    assign bus.fifo_sdata  = rstn ? r_hold : '0;

    ah_sat_counter #(.CNTW(CNTW)) u_push_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_push_inc),
        .cnt  (push_cnt)
    );

    ah_sat_counter #(.CNTW(CNTW)) u_drop_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_drop_inc),
        .cnt  (drop_cnt)
    );
endmodule : ah_snoop_dedup_writer
`default_nettype wire

// File: doc/ah_snoop_dedup_writer.md
Name: ah_snoop_dedup_writer

Overview:
- Upstream write-side stage for the snoopable FIFO (10-bit data, 86 entries).
- Holds each incoming word for one snoop cycle and queries the FIFO's snoop port.
- Drops the word if an identical entry is already queued; otherwise pushes it through the FIFO's valid/ready write port.
- Keeps saturating counters of pushed and dropped words for status readout.

Parameters:
- DW, 10: data width. Must match the FIFO data width.
- CNTW, 16: width of the push/drop statistics counters.

Ports:
- clk  in  1  single clock
- rstn  in  1  synchronous active-low reset
- in_data  in  DW  upstream data
- in_valid  in  1  upstream data valid
- in_ready  out  1  this block can accept in_data
- dedup_en  in  1  1 = snoop and drop duplicates; 0 = pass every word through
- fifo_wdata  out  DW  to FIFO wdata
- fifo_wvalid  out  1  to FIFO wvalid
- fifo_wready  in  1  from FIFO wready
- fifo_sdata  out  DW  to FIFO sdata
- fifo_svalid  out  1  to FIFO svalid
- fifo_smatch  in  1  from FIFO; combinational same-cycle result for fifo_sdata
- push_cnt  out  CNTW  words pushed to FIFO
- drop_cnt  out  CNTW  words dropped as duplicates

Behaviour:
- Reset:
  - Reset is synchronous and active-low; rstn=0 sampled at a clk edge resets the block.
  - State goes to IDLE; hold register and both counters clear.
  - All outputs are 0 during reset except in_ready, which is 0 while rstn=0.
  - A reset mid-operation discards the held word; nothing is pushed for it.
- Single hold register hold_q[DW-1:0]. FSM states are IDLE, SNOOP and PUSH.
- IDLE:
  - in_ready=1.
  - On in_valid: hold_q <= in_data. Next state is SNOOP if dedup_en=1, else PUSH.
- SNOOP:
  - Drives fifo_svalid=1 and fifo_sdata=hold_q; in_ready=0.
  - fifo_smatch is sampled at the end of this cycle.
  - smatch=1: the word is dropped, drop_cnt increments, next state is IDLE.
  - smatch=0: next state is PUSH.
  - SNOOP always lasts exactly 1 cycle.
- PUSH:
  - Drives fifo_wvalid=1 and fifo_wdata=hold_q.
  - While fifo_wready=0: stay in PUSH; wdata is held stable and wvalid is not deasserted.
  - On fifo_wready=1: push_cnt increments.
  - in_ready = fifo_wready, so a back-to-back capture is allowed in the same cycle as the push.
  - If a new word is captured in that cycle, next state is SNOOP (or PUSH when dedup_en=0); otherwise next state is IDLE.
- Timing:
  - dedup_en is sampled at capture time.
  - Latency from capture to fifo_wvalid is 2 cycles with dedup, 1 without.
  - Peak throughput is 1 word per 2 cycles with dedup, 1 word per cycle without.
- Snoop coherency:
  - A word pushed at edge N is visible to a snoop issued in cycle N+1, because the FIFO registers its write.
  - Consecutive identical inputs are therefore detected as duplicates.
  - An entry popped by the reader after the snoop does not revive a dropped word: the snoop result is final.
- Full FIFO: PUSH stalls indefinitely with no timeout. Upstream backpressure propagates through in_ready=0.
- Counters: +1 per event, saturating at all-ones with no wrap. They are never both incremented in the same cycle.
- fifo_svalid=0 outside SNOOP. fifo_sdata is don't-care when svalid=0 and is driven as hold_q.

Decomposition:
- Shared package ah_snoop_pkg holds:
  - the state enum (IDLE=2'd0, SNOOP=2'd1, PUSH=2'd2)
  - DW_DEFAULT=10
  - FIFO_DEPTH=86
- One sub-module is natural: ah_sat_counter (parameter CNTW; inputs clk, rstn, inc; output cnt), instantiated twice for push_cnt and drop_cnt.

Test Plan:
- Reset then single word: rstn low 2 cycles, then in_data=10'h155 with dedup_en=1 and smatch=0. Required: SNOOP with sdata=10'h155, then PUSH with wdata=10'h155; push_cnt=1, drop_cnt=0.
- Duplicate drop: FIFO model holds 10'h0A3; send 10'h0A3. Required: svalid for 1 cycle, smatch=1, no wvalid, drop_cnt=1, back in IDLE with in_ready=1 the next cycle.
- Back-to-back identical words: send 10'h3FF twice on an empty FIFO model. Required: the first is pushed; the second's snoop sees the just-written entry, so it is dropped. push_cnt=1, drop_cnt=1.
- Backpressure: fifo_wready=0 for 5 cycles during PUSH of 10'h012. Required: wvalid=1 with wdata stable for all 5 cycles and in_ready=0; push occurs on the first wready=1.
- Dedup bypass: dedup_en=0, stream of 8 words each identical to 10'h001, wready=1. Required: svalid never asserted, 8 pushes at 1 per cycle, push_cnt=8.
- Saturation and mid-op reset: with CNTW=4, push 17 words. Required: push_cnt holds at 4'hF. Then assert rstn=0 during PUSH. Required: next cycle wvalid=0 and both counters=0.
